// File: rtl/aes_key_expander_pkg.sv
// Shared constants and types for the AES key-schedule engine.
package aes_pkg;

    // Round constants, one per expansion step.
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Key-length selector as sampled with start.
    localparam logic AES128 = 1'b0;
    localparam logic AES256 = 1'b1;

    // Largest meaningful number of round keys per mode.
    localparam int MAX_KEYS_128 = 11;
    localparam int MAX_KEYS_256 = 15;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_A,
        EMIT_B
    } state_t;

endpackage

// File: rtl/aes_key_expander_if.sv
// Job request and round-key stream between the key extractor, the
// expander and the round-key register bank.
interface aes_key_expander_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             abort;
    logic             mode;
    logic [255:0]     key_in;
    logic             ready;
    logic             busy;
    logic             rk_valid;
    logic             rk_ready;
    logic [127:0]     rk_data;
    logic [IDX_W-1:0] rk_index;
    logic             rk_last;

    // Requester / consumer side.
    modport master (
        output start, abort, mode, key_in, rk_ready,
        input  ready, busy, rk_valid, rk_data, rk_index, rk_last
    );

    // Expander side.
    modport slave (
        input  start, abort, mode, key_in, rk_ready,
        output ready, busy, rk_valid, rk_data, rk_index, rk_last
    );
endinterface

// File: rtl/aes_key_expander_step.sv
// One key-schedule step: step128 for AES-128, the full step256 for AES-256.
// Word w0 of each 128-bit block sits in bits [127:96].
module aes_key_step
    import aes_pkg::*;
(
    input  logic         mode,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic [7:0]   rcon,
    output logic [127:0] new_a,
    output logic [127:0] new_b
);
    logic [31:0] w3_last;
    logic [31:0] sub_rot;
    logic [31:0] sub_new;
    logic [31:0] t;

    // The most recently produced block is A in AES-128 and B in AES-256.
    assign w3_last = (mode == AES256) ? b[31:0] : a[31:0];

    aes_sbox u_sbox (
        .lane1_in  ({w3_last[23:0], w3_last[31:24]}),
        .lane1_out (sub_rot),
        .lane2_in  (new_a[31:0]),
        .lane2_out (sub_new)
    );

    assign t = sub_rot ^ {rcon, 24'h0};

    // Prefix-XOR of the old words, each folded with t.
    assign new_a[127:96] = a[127:96] ^ t;
    assign new_a[95:64]  = new_a[127:96] ^ a[95:64];
    assign new_a[63:32]  = new_a[95:64]  ^ a[63:32];
    assign new_a[31:0]   = new_a[63:32]  ^ a[31:0];

    // Second half: SubWord of the new w3, no rotation and no rcon.
    assign new_b[127:96] = b[127:96] ^ sub_new;
    assign new_b[95:64]  = new_b[127:96] ^ b[95:64];
    assign new_b[63:32]  = new_b[95:64]  ^ b[63:32];
    assign new_b[31:0]   = new_b[63:32]  ^ b[31:0];

endmodule

// File: rtl/aes_sbox.sv
// Two independent AES S-box lanes, four bytes each, purely combinational.
module aes_sbox (
    input  logic [31:0] lane1_in,
    input  logic [31:0] lane2_in,
    output logic [31:0] lane1_out,
    output logic [31:0] lane2_out
);
    // Element 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // One table lookup per byte of each lane.
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign lane1_out[8*i +: 8] = SBOX[lane1_in[8*i +: 8]];
        assign lane2_out[8*i +: 8] = SBOX[lane2_in[8*i +: 8]];
    end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/AES-256 key-schedule engine emitting one 128-bit round
// key per cycle on a valid/ready stream.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = 10,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    aes_key_expander_if.slave   bus
);
    localparam int CNT_128 = (NUM_KEYS < MAX_KEYS_128) ? NUM_KEYS : MAX_KEYS_128;
    localparam logic [IDX_W-1:0] LAST_128 = IDX_W'(CNT_128 - 1);
    localparam logic [IDX_W-1:0] LAST_256 = IDX_W'(NUM_KEYS - 1);

    state_t           state, state_nxt;
    logic [127:0]     a_q, b_q;
    logic [127:0]     new_a, new_b;
    logic             mode_q;
    logic [3:0]       ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic             rk_valid;
    logic             hs;
    logic             at_last;
    logic             load;
    logic             step;

    assign rk_valid = (state != IDLE);
    assign hs       = rk_valid & bus.rk_ready;
    assign at_last  = (idx_q == ((mode_q == AES256) ? LAST_256 : LAST_128));

    aes_key_step u_step (
        .mode  (mode_q),
        .a     (a_q),
        .b     (b_q),
        .rcon  (RCON[ptr_q]),
        .new_a (new_a),
        .new_b (new_b)
    );

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus load/step strobes for the datapath.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = EMIT_A;
                end
            end
            EMIT_A: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (hs) begin
                    if (at_last)               state_nxt = IDLE;
                    else if (mode_q == AES256) state_nxt = EMIT_B;
                    else                       step      = 1'b1;
                end
            end
            EMIT_B: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (hs) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                    end else begin
                        step      = 1'b1;
                        state_nxt = EMIT_A;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Key block registers, rcon pointer and key index.
    // NOTE: the key registers are reset because rk_data is driven straight from
    // them and must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= AES128;
            ptr_q  <= '0;
            idx_q  <= '0;
        end else if (load) begin
            a_q    <= bus.key_in[255:128];
            b_q    <= bus.key_in[127:0];
            mode_q <= bus.mode;
            ptr_q  <= '0;
            idx_q  <= '0;
        end else begin
            if (hs && !bus.abort) idx_q <= idx_q + 1'b1;
            if (step) begin
                a_q   <= new_a;
                ptr_q <= ptr_q + 1'b1;
                if (mode_q == AES256) b_q <= new_b;
            end
        end
    end

    // Outputs come from registers or the state decode only, never from rk_ready.
    assign bus.ready    = (state == IDLE);
    assign bus.busy     = rk_valid;
    assign bus.rk_valid = rk_valid;
    assign bus.rk_data  = (state == EMIT_B) ? b_q : a_q;
    assign bus.rk_index = idx_q;
    assign bus.rk_last  = rk_valid & at_last;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors, default count,
// backpressure, abort/overlap and asynchronous reset.
module tb_aes_key_expander;
    import aes_pkg::*;

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f,
                                       128'hdeadbeefcafef00d0123456789abcdef};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int           sel;
    logic         start_d, abort_d, mode_d, rk_ready_d;
    logic [255:0] key_d;

    aes_key_expander_if #(.IDX_W(4)) bus0 ();
    aes_key_expander_if #(.IDX_W(4)) bus1 ();
    aes_key_expander_if #(.IDX_W(4)) bus2 ();

    assign bus0.start = start_d && (sel == 0);
    assign bus1.start = start_d && (sel == 1);
    assign bus2.start = start_d && (sel == 2);
    assign bus0.abort = abort_d && (sel == 0);
    assign bus1.abort = abort_d && (sel == 1);
    assign bus2.abort = abort_d && (sel == 2);
    assign bus0.mode = mode_d;  assign bus1.mode = mode_d;  assign bus2.mode = mode_d;
    assign bus0.key_in = key_d; assign bus1.key_in = key_d; assign bus2.key_in = key_d;
    assign bus0.rk_ready = rk_ready_d;
    assign bus1.rk_ready = rk_ready_d;
    assign bus2.rk_ready = rk_ready_d;

    aes_key_expander #(.NUM_KEYS(11), .IDX_W(4)) dut128 (.clk(clk), .rst(rst), .bus(bus0));
    aes_key_expander #(.NUM_KEYS(15), .IDX_W(4)) dut256 (.clk(clk), .rst(rst), .bus(bus1));
    aes_key_expander #(.IDX_W(4))                dutdef (.clk(clk), .rst(rst), .bus(bus2));

    // Outputs of the currently selected instance.
    logic         c_ready, c_busy, c_valid, c_last;
    logic [127:0] c_data;
    logic [3:0]   c_index;
    always_comb begin
        c_ready = bus0.ready; c_busy = bus0.busy; c_valid = bus0.rk_valid;
        c_last = bus0.rk_last; c_data = bus0.rk_data; c_index = bus0.rk_index;
        if (sel == 1) begin
            c_ready = bus1.ready; c_busy = bus1.busy; c_valid = bus1.rk_valid;
            c_last = bus1.rk_last; c_data = bus1.rk_data; c_index = bus1.rk_index;
        end else if (sel == 2) begin
            c_ready = bus2.ready; c_busy = bus2.busy; c_valid = bus2.rk_valid;
            c_last = bus2.rk_last; c_data = bus2.rk_data; c_index = bus2.rk_index;
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: FIPS-197 word recurrence ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the field inverse and the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int j = 1; j < 256; j++)
            if (gmul(v, 8'(j)) == 8'h01) inv = 8'(j);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    logic [127:0] model_keys [0:14];
    logic [127:0] got        [0:15];

    task automatic expand_model(input logic m, input logic [255:0] k);
        logic [31:0] w [0:59];
        logic [31:0] temp;
        logic [7:0]  rc;
        int          nk;
        nk = m ? 8 : 4;
        rc = 8'h01;
        for (int j = 0; j < nk; j++) w[j] = k[255 - 32*j -: 32];
        for (int i = nk; i < 60; i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one job from a negedge; returns at the negedge after the last key.
    task automatic run_job(input int s, input logic m, input logic [255:0] k,
                           input int pct, input int n_exp);
        int           hs_cnt, cyc;
        logic         stall, done, rdy;
        logic [127:0] pd;
        logic [3:0]   pi;
        logic         pl;
        expand_model(m, k);
        sel = s; mode_d = m; key_d = k; start_d = 1'b1; rk_ready_d = 1'b0;
        check("ready_before_start", 256'(c_ready), 256'(1'b1));
        @(negedge clk);
        start_d = 1'b0; mode_d = ~m; key_d = ~k;
        check("valid_at_first_cycle", 256'(c_valid), 256'(1'b1));
        hs_cnt = 0; cyc = 0; stall = 1'b0; done = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        while (!done && cyc < 400) begin
            if (stall) begin
                check("stall_valid", 256'(c_valid), 256'(1'b1));
                check("stall_data",  256'(c_data),  256'(pd));
                check("stall_index", 256'(c_index), 256'(pi));
                check("stall_last",  256'(c_last),  256'(pl));
            end
            if (c_valid) begin
                check($sformatf("s%0d_index", s), 256'(c_index), 256'(hs_cnt));
                if (hs_cnt < 15)
                    check($sformatf("s%0d_key%0d", s, hs_cnt), 256'(c_data), 256'(model_keys[hs_cnt]));
                check($sformatf("s%0d_last%0d", s, hs_cnt), 256'(c_last), 256'(hs_cnt == n_exp - 1));
                rdy = (pct >= 100) || ($urandom_range(99) < pct);
                rk_ready_d = rdy;
                stall = !rdy;
                pd = c_data; pi = c_index; pl = c_last;
                if (rdy) begin
                    if (hs_cnt < 16) got[hs_cnt] = c_data;
                    if (c_last) done = 1'b1;
                    hs_cnt++;
                end
            end else begin
                rk_ready_d = 1'b0;
                stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready_d = 1'b0;
        check("job_completed", 256'(done), 256'(1'b1));
        check("handshake_count", 256'(hs_cnt), 256'(n_exp));
        if (pct >= 100) check("no_bubbles", 256'(cyc), 256'(n_exp));
        check("ready_after_last", 256'(c_ready), 256'(1'b1));
        check("busy_after_last",  256'(c_busy),  256'(1'b0));
        check("valid_after_last", 256'(c_valid), 256'(1'b0));
    endtask

    typedef struct {
        int           s;
        logic         m;
        logic [255:0] k;
        int           n;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];
    logic aborted;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, AES128, KEY128, 11, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{0, AES128, KEY128, 11, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[2] = '{0, AES128, KEY128, 11, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[3] = '{1, AES256, KEY256, 15, 1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[4] = '{1, AES256, KEY256, 15, 2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[5] = '{1, AES256, KEY256, 15, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[6] = '{2, AES256, KEY256, 10, 0,  128'h000102030405060708090a0b0c0d0e0f};

        sel = 0; start_d = 1'b0; abort_d = 1'b0; mode_d = 1'b0; rk_ready_d = 1'b0; key_d = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_ready",    256'(c_ready), 256'(1'b1));
        check("reset_busy",     256'(c_busy),  256'(1'b0));
        check("reset_valid",    256'(c_valid), 256'(1'b0));
        check("reset_data",     256'(c_data),  256'(0));
        check("reset_index",    256'(c_index), 256'(0));
        check("reset_last",     256'(c_last),  256'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 vectors and the default count, back to back.
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].s, vecs[i].m, vecs[i].k, 100, vecs[i].n);
            check($sformatf("vec%0d_key%0d", i, vecs[i].idx), 256'(got[vecs[i].idx]), 256'(vecs[i].exp));
        end

        // Random backpressure on every instance.
        run_job(0, AES128, KEY128, 40, 11);
        run_job(1, AES256, KEY256, 40, 15);
        run_job(2, AES256, KEY256, 40, 10);

        // Abort at index 4 with a start pulse ignored while busy.
        expand_model(AES256, KEY256);
        sel = 2; mode_d = AES256; key_d = KEY256; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0; rk_ready_d = 1'b1; aborted = 1'b0;
        for (int c = 0; c < 40 && !aborted; c++) begin
            if (c_index < 15)
                check($sformatf("abort_run_key%0d", c_index), 256'(c_data), 256'(model_keys[c_index]));
            if (c_index == 2) begin
                start_d = 1'b1; key_d = ~KEY256; mode_d = AES128;
            end else begin
                start_d = 1'b0;
            end
            if (c_index == 4) begin
                abort_d = 1'b1; aborted = 1'b1;
            end
            @(negedge clk);
        end
        abort_d = 1'b0; start_d = 1'b0; rk_ready_d = 1'b0;
        check("abort_reached", 256'(aborted), 256'(1'b1));
        check("abort_valid",   256'(c_valid), 256'(1'b0));
        check("abort_ready",   256'(c_ready), 256'(1'b1));
        run_job(2, AES256, KEY256, 100, 10);

        // start and abort together in IDLE: start wins.
        sel = 2; mode_d = AES256; key_d = KEY256; start_d = 1'b1; abort_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0; abort_d = 1'b0;
        check("start_over_abort_valid", 256'(c_valid), 256'(1'b1));
        check("start_over_abort_index", 256'(c_index), 256'(0));
        check("start_over_abort_data",  256'(c_data),  256'(KEY256[255:128]));
        abort_d = 1'b1;
        @(negedge clk);
        abort_d = 1'b0;
        check("second_abort_ready", 256'(c_ready), 256'(1'b1));

        // Asynchronous reset mid-stream, checked before the next clock edge.
        sel = 1; mode_d = AES256; key_d = KEY256; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0; rk_ready_d = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_valid", 256'(c_valid), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("async_reset_ready", 256'(c_ready), 256'(1'b1));
        check("async_reset_busy",  256'(c_busy),  256'(1'b0));
        check("async_reset_valid", 256'(c_valid), 256'(1'b0));
        check("async_reset_data",  256'(c_data),  256'(0));
        check("async_reset_index", 256'(c_index), 256'(0));
        check("async_reset_last",  256'(c_last),  256'(1'b0));
        rk_ready_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_job(1, AES256, KEY256, 100, 15);
        check("post_reset_key14", 256'(got[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, parametrised AES key-schedule engine producing a stream of 128-bit round keys from a 256-bit key input. Supports AES-256 (CryptoNight scratchpad key schedule, default 10 keys) and AES-128 selected per job. Uses one expansion step per cycle with a valid/ready output stream. Sits between the Keccak-state key extractor and the round-key register bank of the AES round pipelines.

## Interface
- `NUM_KEYS`, default 10: round keys emitted per job; legal 2..15. In AES-128 mode the count is clamped to 11.
- `IDX_W`, default 4: width of `rk_index`.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a job; accepted only when `ready`=1.
- `abort` in 1: synchronous cancel of the running job.
- `mode` in 1: sampled with `start`. 0 = AES-128 using `key_in[255:128]`; 1 = AES-256.
- `key_in` in 256: cipher key, sampled with `start`. Byte 0 is at [255:248].
- `ready` out 1: engine idle, able to accept `start`.
- `busy` out 1: job in progress (inverse of `ready`).
- `rk_valid` out 1: `rk_data` is valid.
- `rk_ready` in 1: consumer accepts the key.
- `rk_data` out 128: round key. Word w0 is at [127:96]; byte order is the FIPS-197 hex string order.
- `rk_index` out IDX_W: index of the round key, 0..NUM_KEYS-1.
- `rk_last` out 1: marks the final key of the job.

## Operation
- **FSM states:** IDLE, EMIT_A, EMIT_B.
- **IDLE:**
  - `start`=1 latches `mode` and `key_in`. State register: A=[255:128], B=[127:0].
  - rcon pointer is set to 0 and `idx` to 0.
  - Next state is EMIT_A.
- **EMIT_A:** `rk_data`=A. On handshake (`rk_valid` & `rk_ready`):
  - AES-256: go to EMIT_B.
  - AES-128: A ← step128(A, rcon[p]), p++, stay in EMIT_A.
- **EMIT_B (AES-256 only):** `rk_data`=B. On handshake: {A,B} ← step256(A, B, rcon[p]), p++, go to EMIT_A.
- **Completion:** the handshake with `rk_last`=1 returns to IDLE and no step is applied.
- **step128 / first half of step256:**
  - t = SubWord(RotWord(w3 of last block)) ^ {rcon,24'h0}.
  - newA = {w0^t, w0^w1^t, w0^w1^w2^t, w0^w1^w2^w3^t}.
- **Second half of step256:**
  - u = SubWord(w3 of newA), no rotation and no rcon.
  - newB = prefix-XOR of B words, each word XORed with u.
- **rcon table:** 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36, stored as 8 bits. The pointer never exceeds 9 for legal NUM_KEYS.
- **Indexing:** `idx` increments on every handshake. `rk_last` = (`idx` == effective count − 1).
- **Stream rules:** `start` is ignored while busy. `mode` and `key_in` are don't-care outside the accepting cycle.
- **abort:** has priority over a handshake. The next state is IDLE, `rk_valid` drops, and the partial stream is not completed. In IDLE, `abort` has no effect. If `start` and `abort` are both high in IDLE, `start` is accepted.

## Timing
- **Reset values:** `ready`=1, `busy`=0, `rk_valid`=0, `rk_data`=0, `rk_index`=0, `rk_last`=0. State goes to IDLE.
- Reset mid-job discards everything immediately (asynchronous reset).
- **Latency:** `start` accepted at edge T gives `rk_valid`=1 from cycle T+1 with key 0.
- **Throughput:** 1 key per cycle with continuous `rk_ready`. No bubble across step boundaries, because the step is combinational from registered state and is registered on the handshake.
- **Backpressure:** while `rk_valid` & !`rk_ready`, `rk_data`, `rk_index` and `rk_last` hold stable and state is frozen.
- **End of job:** the last handshake at edge L gives `ready`=1 in cycle L+1. A new `start` can be accepted at edge L+1, with first key at L+2.
- **Outputs:** all outputs are registered or decoded from FSM state only. There is no combinational path from `rk_ready` to `rk_data`.

## Structure
- **Package `aes_pkg`:**
  - RCON table (10×8).
  - Mode constants AES128=0, AES256=1.
  - Max key counts (11, 15).
  - FSM state enum.
- **Sub-module `aes_key_step`:** combinational.
  - Inputs: mode, A, B, rcon[7:0].
  - Outputs: newA, newB.
  - Instantiates the team's two-lane `aes_sbox`: lane 1 = w3 of the input block, lane 2 = w3 of newA.
- **Top level:** FSM, key registers, counters and the output stream.

## Test plan
- **AES-128 FIPS-197 C.1 vector:** key 000102…0f, `mode`=0, NUM_KEYS=11, `rk_ready`=1.
  - Key 0 = 000102030405060708090a0b0c0d0e0f.
  - Key 10 = 13111d7fe3944a17f307a78b4d2b30c5 with `rk_last`=1.
  - 11 consecutive valid cycles starting T+1.
- **AES-256 FIPS-197 C.3 vector:** key 000102…1f, `mode`=1, NUM_KEYS=15.
  - Key 1 = 101112131415161718191a1b1c1d1e1f.
  - Key 2 = a573c29fa176c498a97fce93a572c09c.
  - Key 14 = 24fc79ccbf0979e9371ac23c6d68de36.
- **Default NUM_KEYS=10, same AES-256 key:** exactly 10 handshakes, `rk_last` on index 9, `ready`=1 the following cycle.
- **Backpressure:** random `rk_ready` (~40% duty) → key sequence identical to the uninterrupted run, and outputs are stable during every stall cycle.
- **Abort and overlap:**
  - `abort` at index 4 → `rk_valid`=0 next cycle and `ready`=1.
  - An immediate new `start` restarts from index 0 with correct keys.
  - `start` pulsed while busy is ignored.
- **Asynchronous reset:** assert `rst` mid-stream between clock edges → outputs go to reset values without waiting for a clock edge; after release, a fresh job completes correctly.
